// File: rtl/cpu_test_sequencer_pkg.sv
// cpu_test_sequencer_pkg
//   Shared definitions for the CPU run-control harness: default PC width,
//   FSM state encoding, verdict codes and a small elaboration-time helper.
package cpu_test_sequencer_pkg;

    localparam int PC_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_RST  = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        RES_PASS    = 2'b00,
        RES_FAIL    = 2'b01,
        RES_HANG    = 2'b10,
        RES_TIMEOUT = 2'b11
    } result_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pc_stall_detector.sv
// pc_stall_detector
//   Tracks the previous PC and a saturating count of consecutive cycles with
//   an unchanged PC. The first enabled cycle after a clear always counts as a
//   change, whatever value pc_q was cleared to.
// Ports:
//   clk      in   1          rising-edge clock
//   rst      in   1          synchronous active-high reset
//   clr      in   1          synchronous clear of pc_q and the stall count
//   en       in   1          update pc_q / stall count this cycle
//   pc       in   PC_WIDTH   observed PC
//   pc_q     out  PC_WIDTH   PC registered on the previous enabled cycle
//   stalled  out  1          stall count has saturated at STALL_CYCLES
module pc_stall_detector #(
    parameter int PC_WIDTH     = 32,
    parameter int STALL_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    input  logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_q,
    output logic                stalled
);

    localparam int SC_W = $clog2(STALL_CYCLES + 1);

    logic [SC_W-1:0] stall_cnt;
    logic            seen;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pc_q      <= '0;
            stall_cnt <= '0;
            seen      <= 1'b0;
        end else if (en) begin
            pc_q <= pc;
            seen <= 1'b1;
            if (!seen || (pc != pc_q)) begin
                stall_cnt <= SC_W'(1);
            end else if (stall_cnt != SC_W'(STALL_CYCLES)) begin
                stall_cnt <= stall_cnt + SC_W'(1);
            end
        end
    end

    assign stalled = (stall_cnt == SC_W'(STALL_CYCLES));

endmodule

// File: rtl/cpu_test_sequencer.sv
// cpu_test_sequencer
//   Run-control harness for cpu_top: sequences the CPU reset (high, low,
//   release), counts run cycles, watches ext_pc and freezes a verdict of
//   pass, fail, hang or timeout.
// Ports:
//   clk         in   1          rising-edge clock
//   rst         in   1          synchronous active-high reset
//   start       in   1          one-cycle pulse; starts a run from IDLE or DONE
//   ext_pc      in   PC_WIDTH   PC observed from cpu_top
//   cpu_rst_n   out  1          active-low reset to cpu_top
//   busy        out  1          high in PRE, RST and RUN
//   done        out  1          high in DONE; verdict valid
//   result      out  2          00 pass, 01 fail_pc, 10 hang, 11 timeout
//   run_cycles  out  CNT_WIDTH  cycles spent in RUN; frozen in DONE
module cpu_test_sequencer #(
    parameter int                PC_WIDTH       = 32,
    parameter int                PRE_CYCLES     = 10,
    parameter int                RST_CYCLES     = 40,
    parameter int                TIMEOUT_CYCLES = 10000,
    parameter int                STALL_CYCLES   = 16,
    parameter logic [PC_WIDTH-1:0] PASS_PC      = 'h40,
    parameter logic [PC_WIDTH-1:0] FAIL_PC      = 'h44,
    parameter int                CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [PC_WIDTH-1:0]  ext_pc,
    output logic                 cpu_rst_n,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           result,
    output logic [CNT_WIDTH-1:0] run_cycles
);

    import cpu_test_sequencer_pkg::*;

    localparam int PH_MAX = max_int(PRE_CYCLES, RST_CYCLES);
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    state_t              state;
    state_t              state_next;
    logic [PH_W-1:0]     phase_cnt;
    logic                phase_last;
    logic [PC_WIDTH-1:0] pc_q;
    logic                stalled;
    logic                term;
    result_t             term_res;

    pc_stall_detector #(
        .PC_WIDTH     (PC_WIDTH),
        .STALL_CYCLES (STALL_CYCLES)
    ) u_stall (
        .clk     (clk),
        .rst     (rst),
        .clr     (state != ST_RUN),
        .en      (state == ST_RUN),
        .pc      (ext_pc),
        .pc_q    (pc_q),
        .stalled (stalled)
    );

    // Phase counter is shared by PRE and RST; it is always zero on entry.
    always_comb begin
        phase_last = 1'b0;
        case (state)
            ST_PRE:  phase_last = (phase_cnt == PH_W'(PRE_CYCLES - 1));
            ST_RST:  phase_last = (phase_cnt == PH_W'(RST_CYCLES - 1));
            default: phase_last = 1'b0;
        endcase
    end

    // Terminating conditions in priority order; first match wins.
    always_comb begin
        term     = 1'b0;
        term_res = RES_PASS;
        if (state == ST_RUN) begin
            if (ext_pc == FAIL_PC) begin
                term     = 1'b1;
                term_res = RES_FAIL;
            end else if (stalled && (pc_q == PASS_PC)) begin
                term     = 1'b1;
                term_res = RES_PASS;
            end else if (stalled) begin
                term     = 1'b1;
                term_res = RES_HANG;
            end else if (run_cycles == CNT_WIDTH'(TIMEOUT_CYCLES)) begin
                term     = 1'b1;
                term_res = RES_TIMEOUT;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (start)      state_next = ST_PRE;
            ST_PRE:  if (phase_last) state_next = ST_RST;
            ST_RST:  if (phase_last) state_next = ST_RUN;
            ST_RUN:  if (term)       state_next = ST_DONE;
            ST_DONE: if (start)      state_next = ST_PRE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Status outputs are registered decodes of the next state, so they line
    // up exactly with the state register without any input-to-output path.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rst_n <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            cpu_rst_n <= (state_next == ST_PRE) || (state_next == ST_RUN);
            busy      <= (state_next == ST_PRE) || (state_next == ST_RST) ||
                         (state_next == ST_RUN);
            done      <= (state_next == ST_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_cnt  <= '0;
            run_cycles <= '0;
            result     <= RES_PASS;
        end else begin
            if (phase_last || !((state == ST_PRE) || (state == ST_RST))) begin
                phase_cnt <= '0;
            end else begin
                phase_cnt <= phase_cnt + PH_W'(1);
            end

            case (state)
                ST_RST: begin
                    if (phase_last) run_cycles <= CNT_WIDTH'(1);
                end
                ST_RUN: begin
                    if (term) begin
                        result <= term_res;
                    end else begin
                        run_cycles <= run_cycles + CNT_WIDTH'(1);
                    end
                end
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        run_cycles <= '0;
                        result     <= RES_PASS;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
